// File: rtl/mux_rr_stream.sv
// mux_rr_stream: NCH-to-1 stream multiplexer with a registered output.
// mode=0 serves the channel chosen by sel; mode=1 rotates fairly across
// the requesting channels, starting after the last channel served.
module mux_rr_stream #(
  parameter int NCH  = 4,
  parameter int W    = 8,
  parameter int SELW = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic [SELW-1:0]   sel,
  input  logic [NCH-1:0]    in_valid,
  input  logic [NCH*W-1:0]  in_data,
  output logic [NCH-1:0]    in_ready,
  output logic              out_valid,
  output logic [W-1:0]      out_data,
  output logic [SELW-1:0]   out_ch,
  input  logic              out_ready
);

  logic            out_valid_q, out_valid_d;
  logic [W-1:0]    out_data_q,  out_data_d;
  logic [SELW-1:0] out_ch_q,    out_ch_d;
  logic [SELW-1:0] ptr_q,       ptr_d;

  logic            load;
  logic            grant_vld;
  logic [SELW-1:0] grant_idx;
  logic [W-1:0]    grant_data;

  // Grant decision: fixed select, or round-robin search from ptr+1 with wrap.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    load      = ~out_valid_q | out_ready;
    grant_vld = 1'b0;
    grant_idx = '0;
    if (!mode) begin
      // sel values >= NCH match no channel and therefore never grant.
      for (int i = 0; i < NCH; i++) begin
        if (sel == SELW'(i) && in_valid[i]) begin
          grant_vld = 1'b1;
          grant_idx = SELW'(i);
        end
      end
    end else begin
      // First pass covers ptr+1..NCH-1, second pass wraps to 0..ptr.
      for (int i = 0; i < NCH; i++) begin
        if (!grant_vld && in_valid[i] && SELW'(i) > ptr_q) begin
          grant_vld = 1'b1;
          grant_idx = SELW'(i);
        end
      end
      for (int i = 0; i < NCH; i++) begin
        if (!grant_vld && in_valid[i] && SELW'(i) <= ptr_q) begin
          grant_vld = 1'b1;
          grant_idx = SELW'(i);
        end
      end
    end
  end

  // Handshake and data steering for the granted channel.
  always_comb begin
    in_ready   = '0;
    grant_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (grant_idx == SELW'(i)) begin
        grant_data  = in_data[i*W +: W];
        in_ready[i] = ~rst & load & grant_vld;
      end
    end
  end

  // Next state of the output register and round-robin pointer.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    if (load) begin
      if (grant_vld) begin
        out_valid_d = 1'b1;
        out_data_d  = grant_data;
        out_ch_d    = grant_idx;
        // Pointer follows the served channel in both modes.
        ptr_d       = grant_idx;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values,
    // independent of statement order.
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= SELW'(NCH - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule
